line_doubler: RTL and testbench

LINE_DOUBLER -- requirements
Module: line_doubler

---
 rtl/line_doubler.sv | 148 ++++++++++++++
 tb/tb_line_doubler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/line_doubler.sv
// 320x240 -> 640x480 line doubler: two ping-pong line buffers filled on request,
// each source pixel shown as a 2x2 block. Debug macro: LINE_DOUBLER_UNDERRUN_DEBUG_EN.
// Ports: Clk, Reset (async, active-low), DRAWX/DRAWY scan position,
//        pix_valid/pix_data source stream in, line_req/line_idx fill request out,
//        R/G/B registered pixel out, underrun sticky error (0 unless debug macro).
module line_doubler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DRAWX,
  input  logic [9:0]  DRAWY,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        line_req,
  output logic [7:0]  line_idx,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        underrun
);

  localparam logic [8:0] LAST = 9'd319;
`ifdef LINE_DOUBLER_UNDERRUN_DEBUG_EN
  localparam logic [23:0] BAD_PIX = 24'hFF00FF;
`else
  localparam logic [23:0] BAD_PIX = 24'h000000;
`endif

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} st_e;

  st_e         state_q, state_d;
  logic [8:0]  wptr_q, wptr_d;
  logic [1:0]  full_q, full_d;
  logic        line_req_q;
  logic [7:0]  line_idx_q;

  logic        frame_req, row_req;
  logic [7:0]  idx_d;
  logic        wr_en, last;

  logic        active, rd_sel;
  logic [8:0]  rd_addr;
  logic [23:0] rd_q;
  logic        act1_q, bad1_q;
  logic [23:0] rgb_q;

  logic [23:0] buf0_q [320];
  logic [23:0] buf1_q [320];

  // Frame prefetch of line 0 on the last row, then one line ahead on even rows.
  assign frame_req = (DRAWX == 10'd0) && (DRAWY == 10'd524);
  assign row_req   = (DRAWX == 10'd0) && !DRAWY[0] && (DRAWY < 10'd478);
  assign idx_d     = frame_req ? 8'd0 : DRAWY[8:1] + 8'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      line_req_q <= 1'b0;
      line_idx_q <= 8'd0;
    end else begin
      line_req_q <= frame_req | row_req;
      if (frame_req | row_req) line_idx_q <= idx_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (line_req_q)
      state_d = FILL;
    else if (state_q == FILL && pix_valid && wptr_q == LAST)
      state_d = IDLE;
  end

  // A new request takes priority; beats start the cycle after it.
  always_comb begin
    wr_en = (state_q == FILL) && !line_req_q && pix_valid;
    last  = wr_en && (wptr_q == LAST);
  end

  always_comb begin
    wptr_d = wptr_q;
    full_d = full_q;
    if (line_req_q) begin
      wptr_d = 9'd0;
      full_d[line_idx_q[0]] = 1'b0;
    end else if (wr_en) begin
      wptr_d = last ? 9'd0 : wptr_q + 9'd1;
      if (last) full_d[line_idx_q[0]] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wptr_q <= 9'd0;
      full_q <= 2'b00;
    end else begin
      wptr_q <= wptr_d;
      full_q <= full_d;
    end
  end

  // Row y shows source line y>>1, which lives in buf[y[1]].
  assign active  = (DRAWX < 10'd640) && (DRAWY < 10'd480);
  assign rd_sel  = DRAWY[1];
  assign rd_addr = active ? DRAWX[9:1] : 9'd0;

  always_ff @(posedge Clk) begin
    if (wr_en && !line_idx_q[0]) buf0_q[wptr_q] <= pix_data;
    if (wr_en &&  line_idx_q[0]) buf1_q[wptr_q] <= pix_data;
    rd_q <= rd_sel ? buf1_q[rd_addr] : buf0_q[rd_addr];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      act1_q <= 1'b0;
      bad1_q <= 1'b0;
      rgb_q  <= 24'd0;
    end else begin
      act1_q <= active;
      bad1_q <= active && !full_q[rd_sel];
      if (!act1_q)     rgb_q <= 24'd0;
      else if (bad1_q) rgb_q <= BAD_PIX;
      else             rgb_q <= rd_q;
    end
  end

`ifdef LINE_DOUBLER_UNDERRUN_DEBUG_EN
  logic underrun_q;
  logic abort;
  assign abort = line_req_q && (state_q == FILL);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) underrun_q <= 1'b0;
    else if (abort || bad1_q) underrun_q <= 1'b1;
  end
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  assign line_req = line_req_q;
  assign line_idx = line_idx_q;
  assign {R, G, B} = rgb_q;

endmodule

// File: tb/tb_line_doubler.sv
// Directed bench for line_doubler: prefetch, doubling, line advance,
// starved fill, blanking and mid-fill reset.
module tb_line_doubler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DRAWX, DRAWY;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        line_req;
  logic [7:0]  line_idx;
  logic [7:0]  R, G, B;
  logic        underrun;
  logic [23:0] rgb;

  int n_chk = 0;
  int n_err = 0;

`ifdef LINE_DOUBLER_UNDERRUN_DEBUG_EN
  localparam logic [23:0] EXP_BAD = 24'hFF00FF;
  localparam logic        EXP_UR  = 1'b1;
`else
  localparam logic [23:0] EXP_BAD = 24'h000000;
  localparam logic        EXP_UR  = 1'b0;
`endif

  line_doubler dut (
    .Clk(Clk), .Reset(Reset),
    .DRAWX(DRAWX), .DRAWY(DRAWY),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .line_req(line_req), .line_idx(line_idx),
    .R(R), .G(G), .B(B),
    .underrun(underrun)
  );

  assign rgb = {R, G, B};

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dbl(int x);
    if (x < 640) return {8'(x >> 1), 16'h0000};
    return 24'h000000;
  endfunction

  task automatic prefetch;
    DRAWY = 10'd524;
    DRAWX = 10'd0;
    tick;
    chk("pf_req", 32'(line_req), 32'd1);
    chk("pf_idx", 32'(line_idx), 32'd0);
    DRAWX = 10'd1;
    tick;
    chk("pf_pulse_end", 32'(line_req), 32'd0);
    chk("pf_state_fill", 32'(dut.state_q), 32'd1);
  endtask

  task automatic scan_row(input int y);
    DRAWY = 10'(y);
    for (int x = 0; x < 642; x++) begin
      DRAWX = 10'(x);
      tick;
      if (x == 0 && y == 0) begin
        chk("row0_req", 32'(line_req), 32'd1);
        chk("row0_idx", 32'(line_idx), 32'd1);
      end
      if (x >= 1) chk($sformatf("dbl_y%0d_x%0d", y, x - 1),
                      32'(rgb), 32'(dbl(x - 1)));
    end
  endtask

  initial begin
    Reset     = 1'b0;
    DRAWX     = 10'd700;
    DRAWY     = 10'd500;
    pix_valid = 1'b0;
    pix_data  = 24'd0;
    #3;
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_req", 32'(line_req), 32'd0);
    chk("rst_idx", 32'(line_idx), 32'd0);
    chk("rst_ur", 32'(underrun), 32'd0);
    chk("rst_full", 32'(dut.full_q), 32'd0);
    tick;
    tick;
    Reset = 1'b1;
    tick;

    // First prefetch with a flat colour.
    prefetch();
    pix_valid = 1'b1;
    pix_data  = 24'h112233;
    repeat (320) tick;
    pix_valid = 1'b0;
    chk("pf_full0", 32'(dut.full_q), 32'd1);
    chk("pf_idle", 32'(dut.state_q), 32'd0);

    DRAWY = 10'd0;
    DRAWX = 10'd4;
    tick;
    DRAWX = 10'd5;
    tick;
    chk("flat_pix", 32'(rgb), 32'h112233);
    DRAWX = 10'd700;
    tick;

    // Second prefetch with a ramp, then stray beats in IDLE.
    prefetch();
    pix_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      pix_data = {8'(i), 16'h0000};
      tick;
    end
    pix_data = 24'hABCDEF;
    repeat (5) tick;
    pix_valid = 1'b0;
    chk("idle_wptr", 32'(dut.wptr_q), 32'd0);
    chk("idle_state", 32'(dut.state_q), 32'd0);

    scan_row(0);
    scan_row(1);
    chk("dbl_ur", 32'(underrun), 32'd0);

    // Starve the line-1 fill, then request line 2.
    pix_valid = 1'b1;
    pix_data  = 24'h445566;
    repeat (100) tick;
    pix_valid = 1'b0;
    chk("starve_wptr", 32'(dut.wptr_q), 32'd100);
    DRAWY = 10'd2;
    DRAWX = 10'd0;
    tick;
    chk("y2_req", 32'(line_req), 32'd1);
    chk("y2_idx", 32'(line_idx), 32'd2);
    for (int x = 1; x < 10; x++) begin
      DRAWX = 10'(x);
      tick;
      chk($sformatf("starve_x%0d", x - 1), 32'(rgb), 32'(EXP_BAD));
    end
    DRAWX = 10'd700;
    tick;
    tick;
    chk("blank_rgb", 32'(rgb), 32'd0);
    chk("starve_ur", 32'(underrun), 32'(EXP_UR));
    chk("starve_full", 32'(dut.full_q), 32'd0);

    // Last requested line and the no-request row.
    DRAWY = 10'd476;
    DRAWX = 10'd0;
    tick;
    chk("y476_req", 32'(line_req), 32'd1);
    chk("y476_idx", 32'(line_idx), 32'd239);
    DRAWX = 10'd1;
    tick;
    DRAWY = 10'd478;
    DRAWX = 10'd0;
    tick;
    chk("y478_noreq", 32'(line_req), 32'd0);
    chk("y478_idx_held", 32'(line_idx), 32'd239);
    DRAWX = 10'd1;
    tick;

    // Reset in the middle of a fill.
    pix_valid = 1'b1;
    pix_data  = 24'h778899;
    repeat (150) tick;
    chk("mid_wptr", 32'(dut.wptr_q), 32'd150);
    Reset = 1'b0;
    #1;
    chk("mrst_rgb", 32'(rgb), 32'd0);
    chk("mrst_req", 32'(line_req), 32'd0);
    chk("mrst_idx", 32'(line_idx), 32'd0);
    chk("mrst_ur", 32'(underrun), 32'd0);
    chk("mrst_full", 32'(dut.full_q), 32'd0);
    chk("mrst_state", 32'(dut.state_q), 32'd0);
    chk("mrst_wptr", 32'(dut.wptr_q), 32'd0);
    tick;
    DRAWX = 10'd700;
    DRAWY = 10'd500;
    Reset = 1'b1;
    repeat (10) tick;
    pix_valid = 1'b0;
    chk("post_wptr", 32'(dut.wptr_q), 32'd0);
    chk("post_state", 32'(dut.state_q), 32'd0);
    chk("post_req", 32'(line_req), 32'd0);
    chk("post_full", 32'(dut.full_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
